// File: rtl/battle_pkg.sv
// Shared definitions for the Battleships board.
// Contents: one-hot cell-state encodings, result codes, FSM and phase
// encodings, and a ceil(log2) helper used to size index signals.
package battle_pkg;

    localparam int ID_W   = 3;   // ship ID width; ID 0 is water
    localparam int CELL_W = 4;   // one-hot cell state width

    // One-hot cell states. GRAY and RED are terminal.
    localparam logic [CELL_W-1:0] CELL_BLUE  = 4'b0001;
    localparam logic [CELL_W-1:0] CELL_GRAY  = 4'b0010;
    localparam logic [CELL_W-1:0] CELL_BLACK = 4'b0100;
    localparam logic [CELL_W-1:0] CELL_RED   = 4'b1000;

    // Shot result codes.
    localparam logic [2:0] RES_MISS    = 3'd0;
    localparam logic [2:0] RES_HIT     = 3'd1;
    localparam logic [2:0] RES_SUNK    = 3'd2;
    localparam logic [2:0] RES_REPEAT  = 3'd3;
    localparam logic [2:0] RES_INVALID = 3'd4;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_SWEEP  = 2'd2,
        FSM_RESP   = 2'd3
    } fsm_e;

    typedef enum logic {
        PH_SETUP = 1'b0,
        PH_PLAY  = 1'b1
    } phase_e;

    // ceil(log2(value)), never less than 1 so it can size a vector.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << res) < value) res = res + 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/board_cell.sv
// One board cell: holds the ship ID placed on it and its one-hot state.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_id_i       load id_i as the cell's ship ID
//   id_i          ship ID to load
//   set_gray_i    BLUE -> GRAY (miss)
//   set_black_i   BLUE -> BLACK (hit)
//   set_red_i     any non-GRAY state -> RED (sunk / adjacent to sunk)
//   id_o          current ship ID
//   state_o       current one-hot state
module board_cell
    import battle_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_id_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic              set_gray_i,
    input  logic              set_black_i,
    input  logic              set_red_i,
    output logic [ID_W-1:0]   id_o,
    output logic [CELL_W-1:0] state_o
);

    logic [ID_W-1:0]   id_q;
    logic [CELL_W-1:0] st_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q <= '0;
            st_q <= CELL_BLUE;
        end else begin
            if (wr_id_i) id_q <= id_i;
            // GRAY is terminal even for red repaint; GRAY/BLACK only leave BLUE.
            if (set_red_i && st_q != CELL_GRAY)          st_q <= CELL_RED;
            else if (set_gray_i && st_q == CELL_BLUE)    st_q <= CELL_GRAY;
            else if (set_black_i && st_q == CELL_BLUE)   st_q <= CELL_BLACK;
        end
    end

    assign id_o    = id_q;
    assign state_o = st_q;

endmodule

// File: rtl/battle_board.sv
// Battleships board: ship placement in SETUP, shot handling in PLAY with
// per-ship hit counting and a full-board sweep that paints a sunk ship
// (and optionally its 8-neighbourhood) RED.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   place_valid/row/col/id       place one ship segment (SETUP only)
//   place_err                    one-cycle pulse: placement rejected
//   start                        SETUP -> PLAY
//   shot_valid/ready/row/col     shot request handshake
//   result_valid/code/id         one-cycle shot result
//   all_sunk                     every placed ship is sunk
//   board_state                  4 bits per cell, cell r*COLS+c at [4*(r*COLS+c)+:4]
//   dbg_state                    {phase, fsm state} for observation
//
// Shot handshake: a shot is taken on the rising edge where shot_valid and
// shot_ready are both high; row/col are sampled only on that edge. shot_ready
// is low while a shot is in flight, outside PLAY, and after all ships sink.
// result_valid is a single-cycle pulse with no backpressure.
module battle_board
    import battle_pkg::*;
#(
    parameter int ROWS      = 10,
    parameter int COLS      = 10,
    parameter int NUM_SHIPS = 5,
    parameter int MARK_ADJ  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     place_valid,
    input  logic [3:0]               place_row,
    input  logic [3:0]               place_col,
    input  logic [2:0]               place_id,
    output logic                     place_err,
    input  logic                     start,
    input  logic                     shot_valid,
    output logic                     shot_ready,
    input  logic [3:0]               shot_row,
    input  logic [3:0]               shot_col,
    output logic                     result_valid,
    output logic [2:0]               result_code,
    output logic [2:0]               result_id,
    output logic                     all_sunk,
    output logic [4*ROWS*COLS-1:0]   board_state,
    output logic [2:0]               dbg_state
);

    localparam int NCELLS = ROWS * COLS;
    localparam int IDX_W  = clog2(NCELLS);
    localparam int SID_W  = clog2(NUM_SHIPS);

    // Cell array
    logic [ID_W-1:0]   cell_id [NCELLS];
    logic [CELL_W-1:0] cell_st [NCELLS];
    logic [NCELLS-1:0] wr_en, set_gray, set_black, set_red;

    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        board_cell u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .wr_id_i     (wr_en[i]),
            .id_i        (place_id),
            .set_gray_i  (set_gray[i]),
            .set_black_i (set_black[i]),
            .set_red_i   (set_red[i]),
            .id_o        (cell_id[i]),
            .state_o     (cell_st[i])
        );
        assign board_state[4*i +: 4] = cell_st[i];
    end

    // State
    phase_e              phase_q, phase_d;
    fsm_e                state_q, state_d;
    logic [3:0]          sr_q, sr_d, sc_q, sc_d;          // captured shot
    logic [3:0]          sw_r_q, sw_r_d, sw_c_q, sw_c_d;  // sweep position
    logic [ID_W-1:0]     sunk_id_q, sunk_id_d;
    logic [2:0]          res_code_q, res_code_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic [ID_W-1:0]     len_q [NUM_SHIPS];
    logic [ID_W-1:0]     len_d [NUM_SHIPS];
    logic [ID_W-1:0]     hit_q [NUM_SHIPS];
    logic [ID_W-1:0]     hit_d [NUM_SHIPS];
    logic [NUM_SHIPS-1:0] sunk_q, sunk_d;
    logic                place_err_q, place_err_d;
    logic                all_sunk_q, all_sunk_d;

    // Row/col index decode
    logic              p_in_range, place_ok;
    logic [IDX_W-1:0]  p_idx;
    logic [SID_W-1:0]  p_sid;
    logic              s_in_range;
    logic [IDX_W-1:0]  s_idx;
    logic [SID_W-1:0]  s_sid;
    logic [IDX_W-1:0]  w_idx;

    always_comb begin
        p_in_range = (int'(place_row) < ROWS) && (int'(place_col) < COLS);
        p_idx      = p_in_range ? IDX_W'(int'(place_row) * COLS + int'(place_col)) : '0;
        p_sid      = SID_W'(place_id - 3'd1);
        place_ok   = p_in_range && (place_id != '0) && (int'(place_id) <= NUM_SHIPS)
                     && (cell_id[p_idx] == '0);

        s_in_range = (int'(sr_q) < ROWS) && (int'(sc_q) < COLS);
        s_idx      = s_in_range ? IDX_W'(int'(sr_q) * COLS + int'(sc_q)) : '0;
        s_sid      = SID_W'(cell_id[s_idx] - 3'd1);

        w_idx      = IDX_W'(int'(sw_r_q) * COLS + int'(sw_c_q));
    end

    // Does any in-range 8-neighbour of the current sweep cell belong to the sunk ship?
    logic nb_hit;
    always_comb begin
        nb_hit = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0)
                    && (int'(sw_r_q) + dr >= 0) && (int'(sw_r_q) + dr < ROWS)
                    && (int'(sw_c_q) + dc >= 0) && (int'(sw_c_q) + dc < COLS)) begin
                    if (cell_id[IDX_W'((int'(sw_r_q) + dr) * COLS + int'(sw_c_q) + dc)] == sunk_id_q)
                        nb_hit = 1'b1;
                end
            end
        end
    end

    // Every nonzero-length ship sunk, and at least one exists.
    logic all_done;
    always_comb begin
        logic any_ship;
        logic none_left;
        any_ship  = 1'b0;
        none_left = 1'b1;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            if (len_q[i] != '0) begin
                any_ship = 1'b1;
                if (!sunk_q[i]) none_left = 1'b0;
            end
        end
        all_done = any_ship && none_left;
    end

    assign shot_ready = (phase_q == PH_PLAY) && (state_q == FSM_IDLE) && !all_sunk_q;

    // Next-state / cell-control logic
    always_comb begin
        phase_d     = phase_q;
        state_d     = state_q;
        sr_d        = sr_q;
        sc_d        = sc_q;
        sw_r_d      = sw_r_q;
        sw_c_d      = sw_c_q;
        sunk_id_d   = sunk_id_q;
        res_code_d  = res_code_q;
        res_id_d    = res_id_q;
        len_d       = len_q;
        hit_d       = hit_q;
        sunk_d      = sunk_q;
        place_err_d = 1'b0;
        all_sunk_d  = all_sunk_q;
        wr_en       = '0;
        set_gray    = '0;
        set_black   = '0;
        set_red     = '0;

        // Placement is evaluated in the same cycle as start, so it lands first.
        if (phase_q == PH_SETUP) begin
            if (place_valid) begin
                if (place_ok) begin
                    wr_en[p_idx] = 1'b1;
                    // Length saturates so the hit counter can always reach it.
                    if (len_q[p_sid] != '1) len_d[p_sid] = len_q[p_sid] + ID_W'(1);
                end else begin
                    place_err_d = 1'b1;
                end
            end
            if (start) phase_d = PH_PLAY;
        end

        case (state_q)
            FSM_IDLE: begin
                if (shot_valid && shot_ready) begin
                    sr_d    = shot_row;
                    sc_d    = shot_col;
                    state_d = FSM_LOOKUP;
                end
            end
            FSM_LOOKUP: begin
                state_d  = FSM_RESP;
                res_id_d = '0;
                if (!s_in_range) begin
                    res_code_d = RES_INVALID;
                end else if (cell_st[s_idx] != CELL_BLUE) begin
                    res_code_d = RES_REPEAT;
                end else if (cell_id[s_idx] == '0) begin
                    res_code_d      = RES_MISS;
                    set_gray[s_idx] = 1'b1;
                end else begin
                    set_black[s_idx] = 1'b1;
                    hit_d[s_sid]     = hit_q[s_sid] + ID_W'(1);
                    res_id_d         = cell_id[s_idx];
                    if (hit_q[s_sid] + ID_W'(1) == len_q[s_sid]) begin
                        res_code_d    = RES_SUNK;
                        sunk_id_d     = cell_id[s_idx];
                        sunk_d[s_sid] = 1'b1;
                        sw_r_d        = '0;
                        sw_c_d        = '0;
                        state_d       = FSM_SWEEP;
                    end else begin
                        res_code_d = RES_HIT;
                    end
                end
            end
            FSM_SWEEP: begin
                if (cell_id[w_idx] == sunk_id_q)
                    set_red[w_idx] = 1'b1;
                else if (MARK_ADJ != 0 && cell_st[w_idx] == CELL_BLUE && nb_hit)
                    set_red[w_idx] = 1'b1;

                if (sw_c_q == 4'(COLS - 1)) begin
                    sw_c_d = '0;
                    if (sw_r_q == 4'(ROWS - 1)) begin
                        state_d    = FSM_RESP;
                        all_sunk_d = all_done;
                    end else begin
                        sw_r_d = sw_r_q + 4'd1;
                    end
                end else begin
                    sw_c_d = sw_c_q + 4'd1;
                end
            end
            FSM_RESP: state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH_SETUP;
            state_q     <= FSM_IDLE;
            sr_q        <= '0;
            sc_q        <= '0;
            sw_r_q      <= '0;
            sw_c_q      <= '0;
            sunk_id_q   <= '0;
            res_code_q  <= '0;
            res_id_q    <= '0;
            sunk_q      <= '0;
            place_err_q <= 1'b0;
            all_sunk_q  <= 1'b0;
            for (int i = 0; i < NUM_SHIPS; i++) begin
                len_q[i] <= '0;
                hit_q[i] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            sc_q        <= sc_d;
            sw_r_q      <= sw_r_d;
            sw_c_q      <= sw_c_d;
            sunk_id_q   <= sunk_id_d;
            res_code_q  <= res_code_d;
            res_id_q    <= res_id_d;
            sunk_q      <= sunk_d;
            place_err_q <= place_err_d;
            all_sunk_q  <= all_sunk_d;
            len_q       <= len_d;
            hit_q       <= hit_d;
        end
    end

    assign result_valid = (state_q == FSM_RESP);
    assign result_code  = result_valid ? res_code_q : '0;
    assign result_id    = result_valid ? res_id_q : '0;
    assign place_err    = place_err_q;
    assign all_sunk     = all_sunk_q;
    assign dbg_state    = {phase_q, state_q};

endmodule

// File: tb/tb_battle_board.sv
module tb_battle_board;

  localparam logic [3:0] BLUE  = 4'b0001;
  localparam logic [3:0] GRAY  = 4'b0010;
  localparam logic [3:0] BLACK = 4'b0100;
  localparam logic [3:0] RED   = 4'b1000;
  localparam logic [2:0] MISS = 3'd0, HIT = 3'd1, SUNK = 3'd2, REPEAT = 3'd3, INVALID = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // big board: 10x10, MARK_ADJ=1
  logic       b_place_valid, b_start, b_shot_valid;
  logic [3:0] b_place_row, b_place_col, b_shot_row, b_shot_col;
  logic [2:0] b_place_id;
  logic       b_place_err, b_shot_ready, b_result_valid, b_all_sunk;
  logic [2:0] b_result_code, b_result_id, b_dbg;
  logic [399:0] b_board;

  // small board: 4x6, MARK_ADJ=0
  logic       s_place_valid, s_start, s_shot_valid;
  logic [3:0] s_place_row, s_place_col, s_shot_row, s_shot_col;
  logic [2:0] s_place_id;
  logic       s_place_err, s_shot_ready, s_result_valid, s_all_sunk;
  logic [2:0] s_result_code, s_result_id, s_dbg;
  logic [95:0] s_board;

  battle_board #(.ROWS(10), .COLS(10), .NUM_SHIPS(5), .MARK_ADJ(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .place_valid(b_place_valid), .place_row(b_place_row), .place_col(b_place_col),
    .place_id(b_place_id), .place_err(b_place_err), .start(b_start),
    .shot_valid(b_shot_valid), .shot_ready(b_shot_ready),
    .shot_row(b_shot_row), .shot_col(b_shot_col),
    .result_valid(b_result_valid), .result_code(b_result_code), .result_id(b_result_id),
    .all_sunk(b_all_sunk), .board_state(b_board), .dbg_state(b_dbg)
  );

  battle_board #(.ROWS(4), .COLS(6), .NUM_SHIPS(5), .MARK_ADJ(0)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .place_valid(s_place_valid), .place_row(s_place_row), .place_col(s_place_col),
    .place_id(s_place_id), .place_err(s_place_err), .start(s_start),
    .shot_valid(s_shot_valid), .shot_ready(s_shot_ready),
    .shot_row(s_shot_row), .shot_col(s_shot_col),
    .result_valid(s_result_valid), .result_code(s_result_code), .result_id(s_result_id),
    .all_sunk(s_all_sunk), .board_state(s_board), .dbg_state(s_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];   // {code, id}
  int         lat_q[$];   // negedges from accept to result_valid
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [3:0] cell_at(input bit sm, input int r, input int c);
    if (sm) return s_board[4*(r*6+c) +: 4];
    else    return b_board[4*(r*10+c) +: 4];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_place(input bit sm, input int r, input int c, input int id, input logic exp_err);
    @(negedge clk);
    if (sm) begin
      s_place_valid = 1'b1; s_place_row = 4'(r); s_place_col = 4'(c); s_place_id = 3'(id);
    end else begin
      b_place_valid = 1'b1; b_place_row = 4'(r); b_place_col = 4'(c); b_place_id = 3'(id);
    end
    @(negedge clk);
    b_place_valid = 1'b0;
    s_place_valid = 1'b0;
    n_checks++;
    if ((sm ? s_place_err : b_place_err) !== exp_err)
      $display("FAIL place_err (%0d,%0d) id%0d: got %b want %b", r, c, id, sm ? s_place_err : b_place_err, exp_err);
    else n_pass++;
    if (exp_err) begin
      @(negedge clk);
      n_checks++;
      if ((sm ? s_place_err : b_place_err) !== 1'b0)
        $display("FAIL place_err_pulse: got %b want 0", sm ? s_place_err : b_place_err);
      else n_pass++;
    end
  endtask

  task automatic do_start(input bit sm);
    @(negedge clk);
    if (sm) s_start = 1'b1; else b_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic do_shot(input bit sm, input int r, input int c, input logic [2:0] code,
                         input logic [2:0] id, input int lat, input logic exp_all);
    int n;
    logic [5:0] e;
    int el;
    exp_q.push_back({code, id});
    lat_q.push_back(lat);
    @(negedge clk);
    n_checks++;
    if ((sm ? s_shot_ready : b_shot_ready) !== 1'b1)
      $display("FAIL shot_ready_idle (%0d,%0d): got %b want 1", r, c, sm ? s_shot_ready : b_shot_ready);
    else n_pass++;
    if (sm) begin
      s_shot_valid = 1'b1; s_shot_row = 4'(r); s_shot_col = 4'(c);
    end else begin
      b_shot_valid = 1'b1; b_shot_row = 4'(r); b_shot_col = 4'(c);
    end
    @(negedge clk);
    s_shot_valid = 1'b0;
    b_shot_valid = 1'b0;
    n = 0;
    while ((sm ? s_result_valid : b_result_valid) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    n_checks++;
    if ((sm ? s_result_valid : b_result_valid) !== 1'b1) begin
      $display("FAIL result_timeout (%0d,%0d): got no result want code %0d", r, c, e[5:3]);
      return;
    end
    n_pass++;
    n_checks++;
    if ((sm ? {s_result_code, s_result_id} : {b_result_code, b_result_id}) !== e)
      $display("FAIL result (%0d,%0d): got code %0d id %0d want code %0d id %0d", r, c,
               sm ? s_result_code : b_result_code, sm ? s_result_id : b_result_id, e[5:3], e[2:0]);
    else n_pass++;
    n_checks++;
    if (n !== el) $display("FAIL result_latency (%0d,%0d): got %0d want %0d", r, c, n, el);
    else n_pass++;
    n_checks++;
    if ((sm ? s_all_sunk : b_all_sunk) !== exp_all)
      $display("FAIL all_sunk (%0d,%0d): got %b want %b", r, c, sm ? s_all_sunk : b_all_sunk, exp_all);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ((sm ? s_result_valid : b_result_valid) !== 1'b0)
      $display("FAIL result_pulse (%0d,%0d): got 1 want 0", r, c);
    else n_pass++;
  endtask

  task automatic check_cell(input bit sm, input int r, input int c, input logic [3:0] want);
    n_checks++;
    if (cell_at(sm, r, c) !== want)
      $display("FAIL cell(%0d,%0d): got %b want %b", r, c, cell_at(sm, r, c), want);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (b_board !== {100{BLUE}}) $display("FAIL reset_board: got %h want all 0001", b_board);
    else n_pass++;
    n_checks++;
    if (s_board !== {24{BLUE}}) $display("FAIL reset_board_small: got %h want all 0001", s_board);
    else n_pass++;
    n_checks++;
    if ({b_place_err, b_shot_ready, b_result_valid, b_result_code, b_result_id, b_all_sunk, b_dbg} !== 13'd0)
      $display("FAIL reset_outputs: got %b want 0", {b_place_err, b_shot_ready, b_result_valid,
               b_result_code, b_result_id, b_all_sunk, b_dbg});
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_place();
    do_place(0, 2, 3, 1, 1'b0);
    do_place(0, 2, 3, 1, 1'b1);   // occupied
    do_place(0, 10, 0, 1, 1'b1);  // row out of range
    do_place(0, 0, 10, 1, 1'b1);  // col out of range
    do_place(0, 4, 4, 0, 1'b1);   // water ID
    do_place(0, 4, 4, 6, 1'b1);   // ID above NUM_SHIPS
    do_place(0, 0, 0, 2, 1'b0);
    do_place(0, 0, 1, 2, 1'b0);
    check_cell(0, 2, 3, BLUE);
    // placement in the same cycle as start still lands
    @(negedge clk);
    b_place_valid = 1'b1; b_place_row = 4'd7; b_place_col = 4'd7; b_place_id = 3'd3; b_start = 1'b1;
    @(negedge clk);
    b_place_valid = 1'b0; b_start = 1'b0;
    n_checks++;
    if (b_place_err !== 1'b0) $display("FAIL place_with_start: got %b want 0", b_place_err);
    else n_pass++;
    // in PLAY placements are ignored without error
    do_place(0, 8, 8, 4, 1'b0);
  endtask

  task automatic test_miss_repeat();
    do_shot(0, 5, 5, MISS, 3'd0, 1, 1'b0);
    check_cell(0, 5, 5, GRAY);
    do_shot(0, 5, 5, REPEAT, 3'd0, 1, 1'b0);
    check_cell(0, 5, 5, GRAY);
  endtask

  task automatic test_hit_sunk();
    do_shot(0, 0, 0, HIT, 3'd2, 1, 1'b0);
    check_cell(0, 0, 0, BLACK);
    do_shot(0, 0, 1, SUNK, 3'd2, 101, 1'b0);
    check_cell(0, 0, 0, RED);
    check_cell(0, 0, 1, RED);
    check_cell(0, 1, 0, RED);
    check_cell(0, 1, 1, RED);
    check_cell(0, 1, 2, RED);
    check_cell(0, 0, 2, RED);
    check_cell(0, 0, 3, BLUE);
    check_cell(0, 2, 0, BLUE);
    check_cell(0, 2, 3, BLUE);
    check_cell(0, 5, 5, GRAY);
    do_shot(0, 0, 0, REPEAT, 3'd0, 1, 1'b0);
  endtask

  task automatic test_busy();
    int spurious;
    logic [5:0] e;
    exp_q.push_back({INVALID, 3'd0});
    @(negedge clk);
    b_shot_valid = 1'b1; b_shot_row = 4'd10; b_shot_col = 4'd3;
    @(negedge clk);   // accepted; now LOOKUP, valid still held
    n_checks++;
    if ({b_shot_ready, b_result_valid} !== 2'b00)
      $display("FAIL busy_lookup: got ready %b valid %b want 0 0", b_shot_ready, b_result_valid);
    else n_pass++;
    @(negedge clk);   // RESP
    e = exp_q.pop_front();
    n_checks++;
    if ({b_shot_ready, b_result_valid, b_result_code, b_result_id} !== {2'b01, e})
      $display("FAIL busy_resp: got ready %b valid %b code %0d id %0d want 0 1 %0d %0d",
               b_shot_ready, b_result_valid, b_result_code, b_result_id, e[5:3], e[2:0]);
    else n_pass++;
    b_shot_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b_shot_ready, b_result_valid} !== 2'b10)
      $display("FAIL busy_after: got ready %b valid %b want 1 0", b_shot_ready, b_result_valid);
    else n_pass++;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (b_result_valid !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) $display("FAIL busy_extra_result: got %0d want 0", spurious);
    else n_pass++;
  endtask

  task automatic test_all_sunk();
    int spurious;
    do_shot(0, 8, 8, MISS, 3'd0, 1, 1'b0);          // PLAY placement had no effect
    do_shot(0, 2, 3, SUNK, 3'd1, 101, 1'b0);        // single-segment ship 1
    check_cell(0, 3, 4, RED);
    check_cell(0, 2, 3, RED);
    do_shot(0, 7, 7, SUNK, 3'd3, 101, 1'b1);        // last ship
    check_cell(0, 7, 7, RED);
    check_cell(0, 6, 6, RED);
    check_cell(0, 8, 8, GRAY);
    check_cell(0, 9, 9, BLUE);
    spurious = 0;
    b_shot_valid = 1'b1; b_shot_row = 4'd9; b_shot_col = 4'd9;
    repeat (6) begin
      @(negedge clk);
      if (b_shot_ready !== 1'b0 || b_result_valid !== 1'b0) spurious++;
    end
    b_shot_valid = 1'b0;
    n_checks++;
    if (spurious != 0) $display("FAIL ready_after_all_sunk: got %0d active cycles want 0", spurious);
    else n_pass++;
  endtask

  task automatic test_small_board();
    do_place(1, 0, 0, 2, 1'b0);
    do_place(1, 0, 1, 2, 1'b0);
    do_place(1, 4, 0, 1, 1'b1);   // row 4 out of range on 4 rows
    do_start(1);
    do_shot(1, 4, 0, INVALID, 3'd0, 1, 1'b0);
    do_shot(1, 0, 6, INVALID, 3'd0, 1, 1'b0);
    do_shot(1, 0, 0, HIT, 3'd2, 1, 1'b0);
    do_shot(1, 0, 1, SUNK, 3'd2, 25, 1'b1);
    check_cell(1, 0, 0, RED);
    check_cell(1, 0, 1, RED);
    check_cell(1, 1, 0, BLUE);
    check_cell(1, 1, 1, BLUE);
    check_cell(1, 0, 2, BLUE);
  endtask

  task automatic test_reset_mid_sweep();
    int pulses;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_place(0, 3, 3, 1, 1'b0);
    do_start(0);
    @(negedge clk);
    b_shot_valid = 1'b1; b_shot_row = 4'd3; b_shot_col = 4'd3;
    @(negedge clk);
    b_shot_valid = 1'b0;
    repeat (30) @(negedge clk);   // sweep has covered cells 0..28
    n_checks++;
    if (b_dbg !== 3'b110) $display("FAIL mid_sweep_state: got %b want 110", b_dbg);
    else n_pass++;
    check_cell(0, 2, 2, RED);
    check_cell(0, 3, 3, BLACK);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (b_board !== {100{BLUE}}) $display("FAIL reset_mid_sweep_board: got %h want all 0001", b_board);
    else n_pass++;
    n_checks++;
    if ({b_dbg, b_result_valid, b_shot_ready, b_all_sunk} !== 6'd0)
      $display("FAIL reset_mid_sweep_ctrl: got %b want 0", {b_dbg, b_result_valid, b_shot_ready, b_all_sunk});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      if (b_result_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL reset_mid_sweep_result: got %0d pulses want 0", pulses);
    else n_pass++;
    n_checks++;
    if (b_board !== {100{BLUE}}) $display("FAIL reset_mid_sweep_after: got %h want all 0001", b_board);
    else n_pass++;
    do_place(0, 3, 3, 1, 1'b0);   // back in SETUP with a clean board
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n = 1'b0;
    b_place_valid = 1'b0; b_place_row = '0; b_place_col = '0; b_place_id = '0;
    b_start = 1'b0; b_shot_valid = 1'b0; b_shot_row = '0; b_shot_col = '0;
    s_place_valid = 1'b0; s_place_row = '0; s_place_col = '0; s_place_id = '0;
    s_start = 1'b0; s_shot_valid = 1'b0; s_shot_row = '0; s_shot_col = '0;

    test_reset();
    test_place();
    test_miss_repeat();
    test_hit_sunk();
    test_busy();
    test_all_sunk();
    test_small_board();
    test_reset_mid_sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
